// File: rtl/roic_readout_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : roic_readout_sequencer
// Brief    : Walks enabled ROIC channels per row, issuing one-hot read strobes
//            and dummy slots paced by downstream ready; reports row/frame done.
// Revision : 1.0 - initial release
// ============================================================================
module roic_readout_sequencer #(
    parameter int NUM_CH       = 12,
    parameter int WORDS_PER_CH = 256,
    parameter int DUMMY_WORDS  = 4,
    parameter int ROW_W        = 12,
    parameter int WORD_W       = (WORDS_PER_CH > 1) ? $clog2(WORDS_PER_CH) : 1
) (
    input  logic              i_eim_clk,
    input  logic              i_eim_rst,
    input  logic              i_frame_start,
    input  logic [ROW_W-1:0]  i_num_rows,
    input  logic [NUM_CH-1:0] i_ch_enable,
    input  logic              i_row_start,
    input  logic              i_rd_ready,
    input  logic              i_abort,
    output logic [NUM_CH-1:0] o_read_mem,
    output logic              o_s_dummy_valid,
    output logic [WORD_W-1:0] o_word_addr,
    output logic [ROW_W-1:0]  o_row_idx,
    output logic              o_busy,
    output logic              o_row_done,
    output logic              o_frame_done,
    output logic              o_row_start_lost
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int DW_W = (DUMMY_WORDS > 1) ? $clog2(DUMMY_WORDS) : 1;
    localparam logic [WORD_W-1:0] c_last_word  = WORD_W'(WORDS_PER_CH - 1);
    localparam logic [DW_W-1:0]   c_last_dummy = DW_W'(DUMMY_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_ROW = 3'd1,
        S_READ     = 3'd2,
        S_DUMMY    = 3'd3,
        S_ROW_END  = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nx;
    logic [NUM_CH-1:0]   r_mask;
    logic [ROW_W-1:0]    r_num_rows;
    logic [ROW_W-1:0]    r_row_idx;
    logic [CH_W-1:0]     r_ch;
    logic [WORD_W-1:0]   r_word_addr;
    logic [DW_W-1:0]     r_dummy_cnt;
    logic                r_lost;

    logic [CH_W-1:0]     w_first_ch;
    logic [CH_W-1:0]     w_next_ch;
    logic                w_next_vld;
    logic                w_last_word;
    logic                w_last_dummy;
    logic                w_last_row;
    logic                w_accept;

    // Downward scan leaves the lowest qualifying channel as the final winner.
    always_comb begin
        w_first_ch = '0;
        w_next_ch  = '0;
        w_next_vld = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (r_mask[i]) begin
                w_first_ch = CH_W'(i);
                if (CH_W'(i) > r_ch) begin
                    w_next_ch  = CH_W'(i);
                    w_next_vld = 1'b1;
                end
            end
        end
    end

    assign w_last_word  = (r_word_addr == c_last_word);
    assign w_last_dummy = (r_dummy_cnt == c_last_dummy);
    assign w_last_row   = (r_row_idx == (r_num_rows - ROW_W'(1)));
    assign w_accept     = i_frame_start && (|i_num_rows) && (|i_ch_enable);

    always_comb begin
        w_state_nx       = r_state;
        o_read_mem       = '0;
        o_s_dummy_valid  = 1'b0;
        o_word_addr      = '0;
        o_row_idx        = '0;
        o_busy           = 1'b0;
        o_row_done       = 1'b0;
        o_frame_done     = 1'b0;
        o_row_start_lost = 1'b0;

        case (r_state)
            S_IDLE:     if (w_accept) w_state_nx = S_WAIT_ROW;
            S_WAIT_ROW: if (i_row_start) w_state_nx = S_READ;
            S_READ: begin
                if (i_rd_ready && w_last_word && !w_next_vld)
                    w_state_nx = (DUMMY_WORDS > 0) ? S_DUMMY : S_ROW_END;
            end
            S_DUMMY:    if (i_rd_ready && w_last_dummy) w_state_nx = S_ROW_END;
            S_ROW_END:  w_state_nx = w_last_row ? S_IDLE : S_WAIT_ROW;
            default:    w_state_nx = S_IDLE;
        endcase

        // Abort blanks every output in the cycle it is seen.
        if (i_abort) begin
            w_state_nx = S_IDLE;
        end else begin
            if (r_state == S_READ && i_rd_ready)
                o_read_mem = NUM_CH'(1) << r_ch;
            o_s_dummy_valid  = (r_state == S_DUMMY) && i_rd_ready;
            o_word_addr      = r_word_addr;
            o_row_idx        = r_row_idx;
            o_busy           = (r_state != S_IDLE);
            o_row_done       = (r_state == S_ROW_END);
            o_frame_done     = (r_state == S_ROW_END) && w_last_row;
            o_row_start_lost = r_lost;
        end
    end

    always_ff @(posedge i_eim_clk or posedge i_eim_rst) begin
        if (i_eim_rst) begin
            r_state     <= S_IDLE;
            r_mask      <= '0;
            r_num_rows  <= '0;
            r_row_idx   <= '0;
            r_ch        <= '0;
            r_word_addr <= '0;
            r_dummy_cnt <= '0;
            r_lost      <= 1'b0;
        end else if (i_abort) begin
            r_state     <= S_IDLE;
            r_mask      <= '0;
            r_num_rows  <= '0;
            r_row_idx   <= '0;
            r_ch        <= '0;
            r_word_addr <= '0;
            r_dummy_cnt <= '0;
            r_lost      <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_lost  <= i_row_start && (r_state == S_READ || r_state == S_DUMMY ||
                                       r_state == S_ROW_END);
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_mask     <= i_ch_enable;
                        r_num_rows <= i_num_rows;
                        r_row_idx  <= '0;
                    end
                end
                S_WAIT_ROW: begin
                    if (i_row_start) begin
                        r_ch        <= w_first_ch;
                        r_word_addr <= '0;
                        r_dummy_cnt <= '0;
                    end
                end
                S_READ: begin
                    if (i_rd_ready) begin
                        if (w_last_word) begin
                            r_word_addr <= '0;
                            if (w_next_vld) r_ch <= w_next_ch;
                        end else begin
                            r_word_addr <= r_word_addr + WORD_W'(1);
                        end
                    end
                end
                S_DUMMY: begin
                    if (i_rd_ready) r_dummy_cnt <= r_dummy_cnt + DW_W'(1);
                end
                S_ROW_END: begin
                    r_dummy_cnt <= '0;
                    r_row_idx   <= w_last_row ? '0 : r_row_idx + ROW_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_roic_readout_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_roic_readout_sequencer
// Brief    : Directed bench: cycle vector table plus frame/abort/reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_roic_readout_sequencer;

    localparam int NCH = 12;
    localparam int WPC = 4;
    localparam int DW  = 2;
    localparam int RW  = 12;
    localparam int WW  = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           fs = 1'b0, rs = 1'b0, rd = 1'b0, ab = 1'b0;
    logic [RW-1:0]  nr = '0;
    logic [NCH-1:0] en = '0;

    logic [NCH-1:0] rm;
    logic           dv, bz, rdn, fdn, lost;
    logic [WW-1:0]  wa;
    logic [RW-1:0]  ri;

    always #5 clk = ~clk;

    roic_readout_sequencer #(
        .NUM_CH(NCH), .WORDS_PER_CH(WPC), .DUMMY_WORDS(DW), .ROW_W(RW)
    ) dut (
        .i_eim_clk(clk), .i_eim_rst(rst), .i_frame_start(fs), .i_num_rows(nr),
        .i_ch_enable(en), .i_row_start(rs), .i_rd_ready(rd), .i_abort(ab),
        .o_read_mem(rm), .o_s_dummy_valid(dv), .o_word_addr(wa), .o_row_idx(ri),
        .o_busy(bz), .o_row_done(rdn), .o_frame_done(fdn), .o_row_start_lost(lost)
    );

    wire [30:0] act = {rm, dv, wa, ri, bz, rdn, fdn, lost};

    int n_checks = 0;
    int n_errors = 0;

    function automatic logic [30:0] pk(input logic [11:0] m, input logic d,
                                       input logic [1:0] w, input logic [11:0] r,
                                       input logic b, input logic rd_n,
                                       input logic fd_n, input logic l);
        return {m, d, w, r, b, rd_n, fd_n, l};
    endfunction

    task automatic check(input string nm, input logic [30:0] a, input logic [30:0] e);
        n_checks++;
        if (a !== e) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (rm,dv,wa,row,busy,rdone,fdone,lost)",
                     nm, a, e);
        end
    endtask

    task automatic cyc(input logic f, input logic r, input logic d, input logic a);
        @(negedge clk);
        fs = f; rs = r; rd = d; ab = a;
        #1;
    endtask

    typedef struct {
        logic        fs;
        logic [11:0] nr;
        logic [11:0] en;
        logic        rs;
        logic        rd;
        logic        ab;
        logic [30:0] exp;
    } vec_t;

    vec_t tbl [0:17];

    function automatic vec_t mkv(input logic f, input logic r, input logic d,
                                 input logic [30:0] e);
        vec_t v;
        v.fs = f; v.nr = 12'd1; v.en = 12'h801; v.rs = r; v.rd = d; v.ab = 1'b0; v.exp = e;
        return v;
    endfunction

    // Full-frame scoreboard: expected slot list built from the mask.
    task automatic run_frame(input logic [11:0] m, input logic [11:0] n, input bit rnd,
                             input string nm);
        int   ch_q[$];
        int   w_q[$];
        int   s;
        int   budget;
        logic d;
        en = m; nr = n;
        cyc(1, 0, 1, 0);
        for (int r = 0; r < int'(n); r++) begin
            cyc(0, 1, 1, 0);
            check(nm, act, pk(12'd0, 0, 2'd0, 12'(r), 1, 0, 0, 0));
            ch_q.delete(); w_q.delete();
            for (int c = 0; c < NCH; c++)
                if (m[c]) for (int w = 0; w < WPC; w++) begin
                    ch_q.push_back(c); w_q.push_back(w);
                end
            s = 0; budget = 0;
            while (s < ch_q.size() + DW && budget < 2000) begin
                d = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                cyc(0, 0, d, 0);
                if (s < ch_q.size())
                    check(nm, act, pk(d ? (12'd1 << ch_q[s]) : 12'd0, 0, 2'(w_q[s]),
                                      12'(r), 1, 0, 0, 0));
                else
                    check(nm, act, pk(12'd0, d, 2'd0, 12'(r), 1, 0, 0, 0));
                if (d) s++;
                budget++;
            end
            if (budget >= 2000) begin
                n_checks++; n_errors++;
                $display("FAIL %s: slot loop timeout, got %0d slots expected %0d",
                         nm, s, ch_q.size() + DW);
            end
            cyc(0, 0, 1, 0);
            check(nm, act, pk(12'd0, 0, 2'd0, 12'(r), 1, 1, (r == int'(n) - 1), 0));
        end
        cyc(0, 0, 1, 0);
        check(nm, act, pk(12'd0, 0, 2'd0, 12'd0, 0, 0, 0, 0));
    endtask

    initial begin
        // One-row frame, mask ch0+ch11: stall, lost row_start, ignored frame_start.
        tbl[0]  = mkv(0, 0, 0, pk(12'h000, 0, 2'd0, 12'd0, 0, 0, 0, 0));
        tbl[1]  = mkv(1, 0, 0, pk(12'h000, 0, 2'd0, 12'd0, 0, 0, 0, 0));
        tbl[2]  = mkv(0, 1, 1, pk(12'h000, 0, 2'd0, 12'd0, 1, 0, 0, 0));
        tbl[3]  = mkv(0, 0, 1, pk(12'h001, 0, 2'd0, 12'd0, 1, 0, 0, 0));
        tbl[4]  = mkv(0, 0, 1, pk(12'h001, 0, 2'd1, 12'd0, 1, 0, 0, 0));
        tbl[5]  = mkv(0, 1, 1, pk(12'h001, 0, 2'd2, 12'd0, 1, 0, 0, 0));
        tbl[6]  = mkv(0, 0, 1, pk(12'h001, 0, 2'd3, 12'd0, 1, 0, 0, 1));
        tbl[7]  = mkv(0, 0, 1, pk(12'h800, 0, 2'd0, 12'd0, 1, 0, 0, 0));
        tbl[8]  = mkv(0, 0, 0, pk(12'h000, 0, 2'd1, 12'd0, 1, 0, 0, 0));
        tbl[9]  = mkv(1, 0, 1, pk(12'h800, 0, 2'd1, 12'd0, 1, 0, 0, 0));
        tbl[10] = mkv(0, 0, 1, pk(12'h800, 0, 2'd2, 12'd0, 1, 0, 0, 0));
        tbl[11] = mkv(0, 0, 1, pk(12'h800, 0, 2'd3, 12'd0, 1, 0, 0, 0));
        tbl[12] = mkv(0, 0, 1, pk(12'h000, 1, 2'd0, 12'd0, 1, 0, 0, 0));
        tbl[13] = mkv(0, 0, 0, pk(12'h000, 0, 2'd0, 12'd0, 1, 0, 0, 0));
        tbl[14] = mkv(0, 0, 1, pk(12'h000, 1, 2'd0, 12'd0, 1, 0, 0, 0));
        tbl[15] = mkv(0, 0, 1, pk(12'h000, 0, 2'd0, 12'd0, 1, 1, 1, 0));
        tbl[16] = mkv(0, 1, 1, pk(12'h000, 0, 2'd0, 12'd0, 0, 0, 0, 0));
        tbl[17] = mkv(0, 0, 1, pk(12'h000, 0, 2'd0, 12'd0, 0, 0, 0, 0));

        repeat (2) @(negedge clk);
        #1;
        check("in_reset", act, 31'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 18; i++) begin
            nr = tbl[i].nr; en = tbl[i].en;
            cyc(tbl[i].fs, tbl[i].rs, tbl[i].rd, tbl[i].ab);
            check($sformatf("vec%0d", i), act, tbl[i].exp);
        end

        run_frame(12'hFFF, 12'd2, 0, "full_mask");
        run_frame(12'h0A5, 12'd1, 0, "sparse_mask");
        run_frame(12'h0A5, 12'd2, 1, "random_ready");
        run_frame(12'hFFF, 12'd1, 1, "random_full");

        // Abort at ch5 word 2.
        en = 12'hFFF; nr = 12'd2;
        cyc(1, 0, 1, 0);
        cyc(0, 1, 1, 0);
        for (int k = 0; k < 22; k++) begin
            cyc(0, 0, 1, 0);
            check("abort_pre", act, pk(12'd1 << (k / 4), 0, 2'(k % 4), 12'd0, 1, 0, 0, 0));
        end
        cyc(0, 0, 0, 0);
        check("abort_stall", act, pk(12'h000, 0, 2'd2, 12'd0, 1, 0, 0, 0));
        cyc(0, 0, 1, 1);
        check("abort_cycle", act, 31'd0);
        cyc(0, 0, 1, 0);
        check("abort_after", act, 31'd0);
        cyc(0, 1, 1, 0);
        check("abort_idle_rs", act, 31'd0);
        cyc(0, 0, 1, 0);
        check("abort_idle_silent", act, 31'd0);
        run_frame(12'h0A5, 12'd1, 0, "after_abort");

        // Rejected frame starts.
        en = 12'h000; nr = 12'd3;
        cyc(1, 0, 1, 0);
        cyc(0, 0, 1, 0);
        check("mask_zero", act, 31'd0);
        en = 12'hFFF; nr = 12'd0;
        cyc(1, 0, 1, 0);
        cyc(0, 0, 1, 0);
        check("rows_zero", act, 31'd0);

        // Asynchronous reset in the middle of the dummy slots.
        en = 12'h001; nr = 12'd1;
        cyc(1, 0, 1, 0);
        cyc(0, 1, 1, 0);
        for (int k = 0; k < 4; k++) begin
            cyc(0, 0, 1, 0);
            check("rst_pre", act, pk(12'h001, 0, 2'(k), 12'd0, 1, 0, 0, 0));
        end
        cyc(0, 0, 1, 0);
        check("rst_dummy", act, pk(12'h000, 1, 2'd0, 12'd0, 1, 0, 0, 0));
        #1 rst = 1'b1;
        #1;
        check("rst_async", act, 31'd0);
        @(negedge clk);
        rst = 1'b0;
        cyc(0, 1, 1, 0);
        check("rst_idle", act, 31'd0);
        cyc(0, 0, 1, 0);
        check("rst_idle_silent", act, 31'd0);
        run_frame(12'h003, 12'd1, 0, "after_reset");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
